// File: rtl/ct_l2cache_tag_ctrl_pkg.sv
// Widths and helpers shared by the L2 tag SRAM controller and its arbiter.
// Widths normally come from cpu_cfig.h; the fallbacks keep this slice standalone.
`ifndef L2C_TAG_DATA_WIDTH
`define L2C_TAG_DATA_WIDTH 8
`endif
`ifndef L2C_TAG_INDEX_WIDTH
`define L2C_TAG_INDEX_WIDTH 4
`endif

package ct_l2cache_tag_ctrl_pkg;
  localparam int WAY_NUM    = 16;
  localparam int TAG_W      = `L2C_TAG_DATA_WIDTH;
  localparam int IDX_W      = `L2C_TAG_INDEX_WIDTH;
  localparam int DW         = WAY_NUM * TAG_W;
  localparam int STARVE_MAX = 7;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  // Active-high way enables become active-low SRAM bit enables.
  function automatic logic [DW-1:0] way_to_wen(input logic [WAY_NUM-1:0] way_wen);
    logic [DW-1:0] wen;
    wen = '1;
    for (int w = 0; w < WAY_NUM; w++) begin
      wen[w*TAG_W +: TAG_W] = {TAG_W{~way_wen[w]}};
    end
    return wen;
  endfunction
endpackage

// File: rtl/ct_l2cache_tag_ctrl_arb.sv
// Two-requester arbiter: A has fixed priority, B is forced after STARVE_MAX lost cycles.
module ct_l2cache_tag_arb
  import ct_l2cache_tag_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_vld,
  input  logic b_vld,
  output logic a_rdy,
  output logic b_rdy,
  output logic grant_b
);
  logic [STARVE_W-1:0] starve_cnt;
  logic                b_force;

  assign b_force = (starve_cnt == STARVE_W'(STARVE_MAX));
  assign a_rdy   = en & ~b_force;
  assign b_rdy   = en & (b_force | ~a_vld);
  assign grant_b = b_vld & b_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_b) begin
      starve_cnt <= '0;
    end else if (b_vld && !b_force) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
endmodule

// File: rtl/ct_l2cache_tag_ctrl.sv
// L2 tag SRAM sequencer: invalidate-all sweep after reset or on request, otherwise
// shares the single SRAM port between requesters A and B.
module ct_l2cache_tag_ctrl
  import ct_l2cache_tag_ctrl_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               a_req_vld,
  output logic               a_req_rdy,
  input  logic               a_req_wr,
  input  logic [IDX_W-1:0]   a_req_idx,
  input  logic [WAY_NUM-1:0] a_req_way_wen,
  input  logic [DW-1:0]      a_req_din,
  input  logic               b_req_vld,
  output logic               b_req_rdy,
  input  logic               b_req_wr,
  input  logic [IDX_W-1:0]   b_req_idx,
  input  logic [WAY_NUM-1:0] b_req_way_wen,
  input  logic [DW-1:0]      b_req_din,
  output logic               rsp_vld,
  output logic               rsp_src,
  output logic [DW-1:0]      rsp_dout,
  input  logic               inv_req,
  output logic               inv_done,
  output logic               init_busy,
  output logic               tag_cen,
  output logic               tag_gwen,
  output logic [IDX_W-1:0]   tag_idx,
  output logic [DW-1:0]      tag_din,
  output logic [DW-1:0]      tag_wen,
  input  logic [DW-1:0]      tag_dout
);
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_idx;
  logic               inv_done_q;
  logic               rsp_vld_q;
  logic               rsp_src_q;
  logic               arb_en;
  logic               arb_a_rdy;
  logic               arb_b_rdy;
  logic               grant_b;
  logic               a_acc;
  logic               acc_rd;
  logic               acc_wr_en;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [WAY_NUM-1:0] acc_way_wen;
  logic [DW-1:0]      acc_din;

  // A pending invalidate request steals the cycle from both requesters.
  assign arb_en = ~cpurst & (state == ST_READY) & ~inv_req;

  ct_l2cache_tag_arb u_arb (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .en      (arb_en),
    .a_vld   (a_req_vld),
    .b_vld   (b_req_vld),
    .a_rdy   (arb_a_rdy),
    .b_rdy   (arb_b_rdy),
    .grant_b (grant_b)
  );

  assign a_acc = a_req_vld & arb_a_rdy & ~grant_b;

  always_comb begin
    acc_wr      = a_req_wr;
    acc_idx     = a_req_idx;
    acc_way_wen = a_req_way_wen;
    acc_din     = a_req_din;
    if (grant_b) begin
      acc_wr      = b_req_wr;
      acc_idx     = b_req_idx;
      acc_way_wen = b_req_way_wen;
      acc_din     = b_req_din;
    end
  end

  assign acc_rd    = (a_acc | grant_b) & ~acc_wr;
  assign acc_wr_en = (a_acc | grant_b) & acc_wr & (|acc_way_wen);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      inv_done_q <= 1'b0;
    end else begin
      inv_done_q <= 1'b0;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == {IDX_W{1'b1}}) begin
            state      <= ST_READY;
            inv_done_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (inv_req) begin
            state    <= ST_INIT;
            init_idx <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rsp_vld_q <= 1'b0;
      rsp_src_q <= 1'b0;
    end else begin
      rsp_vld_q <= acc_rd;
      rsp_src_q <= grant_b;
    end
  end

  // A write with no way enabled is accepted but leaves the SRAM untouched.
  always_comb begin
    tag_cen  = 1'b1;
    tag_gwen = 1'b1;
    tag_idx  = '0;
    tag_din  = '0;
    tag_wen  = '1;
    if (!cpurst) begin
      if (state == ST_INIT) begin
        tag_cen  = 1'b0;
        tag_gwen = 1'b0;
        tag_wen  = '0;
        tag_idx  = init_idx;
      end else if (acc_rd) begin
        tag_cen = 1'b0;
        tag_idx = acc_idx;
      end else if (acc_wr_en) begin
        tag_cen  = 1'b0;
        tag_gwen = 1'b0;
        tag_idx  = acc_idx;
        tag_din  = acc_din;
        tag_wen  = way_to_wen(acc_way_wen);
      end
    end
  end

  assign a_req_rdy = arb_a_rdy;
  assign b_req_rdy = arb_b_rdy;
  assign rsp_vld   = rsp_vld_q & ~cpurst;
  assign rsp_src   = rsp_src_q & ~cpurst;
  assign rsp_dout  = cpurst ? '0 : tag_dout;
  assign inv_done  = inv_done_q & ~cpurst;
  assign init_busy = ~cpurst & (state == ST_INIT);
endmodule

// File: tb/tb_ct_l2cache_tag_ctrl.sv
// Directed bench for ct_l2cache_tag_ctrl with a behavioural tag SRAM model.
module tb_ct_l2cache_tag_ctrl;
  import ct_l2cache_tag_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               cpurst;
  logic               a_req_vld, a_req_rdy, a_req_wr;
  logic [IDX_W-1:0]   a_req_idx;
  logic [WAY_NUM-1:0] a_req_way_wen;
  logic [DW-1:0]      a_req_din;
  logic               b_req_vld, b_req_rdy, b_req_wr;
  logic [IDX_W-1:0]   b_req_idx;
  logic [WAY_NUM-1:0] b_req_way_wen;
  logic [DW-1:0]      b_req_din;
  logic               rsp_vld, rsp_src;
  logic [DW-1:0]      rsp_dout;
  logic               inv_req, inv_done, init_busy;
  logic               tag_cen, tag_gwen;
  logic [IDX_W-1:0]   tag_idx;
  logic [DW-1:0]      tag_din, tag_wen, tag_dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wdata, exp_data, exp_wen;

  always #5 clk = ~clk;

  ct_l2cache_tag_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .a_req_vld      (a_req_vld),
    .a_req_rdy      (a_req_rdy),
    .a_req_wr       (a_req_wr),
    .a_req_idx      (a_req_idx),
    .a_req_way_wen  (a_req_way_wen),
    .a_req_din      (a_req_din),
    .b_req_vld      (b_req_vld),
    .b_req_rdy      (b_req_rdy),
    .b_req_wr       (b_req_wr),
    .b_req_idx      (b_req_idx),
    .b_req_way_wen  (b_req_way_wen),
    .b_req_din      (b_req_din),
    .rsp_vld        (rsp_vld),
    .rsp_src        (rsp_src),
    .rsp_dout       (rsp_dout),
    .inv_req        (inv_req),
    .inv_done       (inv_done),
    .init_busy      (init_busy),
    .tag_cen        (tag_cen),
    .tag_gwen       (tag_gwen),
    .tag_idx        (tag_idx),
    .tag_din        (tag_din),
    .tag_wen        (tag_wen),
    .tag_dout       (tag_dout)
  );

  // Tag SRAM: bit-masked write, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<IDX_W)-1];
  always @(posedge clk) begin
    if (!tag_cen) begin
      if (!tag_gwen) mem[tag_idx] <= (mem[tag_idx] & tag_wen) | (tag_din & ~tag_wen);
      else           tag_dout <= mem[tag_idx];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req_vld = 0; a_req_wr = 0; a_req_idx = '0; a_req_way_wen = '0; a_req_din = '0;
    b_req_vld = 0; b_req_wr = 0; b_req_idx = '0; b_req_way_wen = '0; b_req_din = '0;
    inv_req = 0;
  endtask

  task automatic test_reset();
    int done_cnt;
    done_cnt = 0;
    cpurst = 1;
    idle_inputs();
    repeat (3) next_cycle();
    #1;
    checks++;
    if ({tag_cen, tag_gwen, init_busy, a_req_rdy, b_req_rdy, rsp_vld, inv_done} !== 7'b1100000 ||
        tag_wen !== '1 || tag_idx !== '0 || tag_din !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: cen/gwen/busy/ardy/brdy/rsp/done=%b idx=%0d got, 1100000 idx=0 required",
               {tag_cen, tag_gwen, init_busy, a_req_rdy, b_req_rdy, rsp_vld, inv_done}, tag_idx);
    end
    next_cycle();
    cpurst = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({tag_cen, tag_gwen, init_busy, a_req_rdy, b_req_rdy} !== 5'b00100 ||
          tag_wen !== '0 || tag_din !== '0 || tag_idx !== IDX_W'(i)) begin
        errors++;
        $display("[TB] FAIL reset_sweep[%0d]: cen/gwen/busy/ardy/brdy=%b idx=%0d got, 00100 idx=%0d required",
                 i, {tag_cen, tag_gwen, init_busy, a_req_rdy, b_req_rdy}, tag_idx, i);
      end
      if (inv_done) done_cnt++;
      next_cycle();
    end
    #1;
    checks++;
    if ({inv_done, init_busy, tag_cen, a_req_rdy, b_req_rdy} !== 5'b10111 || done_cnt != 0) begin
      errors++;
      $display("[TB] FAIL reset_done: done/busy/cen/ardy/brdy=%b early_done=%0d got, 10111 0 required",
               {inv_done, init_busy, tag_cen, a_req_rdy, b_req_rdy}, done_cnt);
    end
    next_cycle();
    #1;
    checks++;
    if (inv_done !== 1'b0 || tag_cen !== 1'b1 || tag_wen !== '1) begin
      errors++;
      $display("[TB] FAIL reset_after: done=%b cen=%b got, 0 1 required", inv_done, tag_cen);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    wdata = '1;
    wdata[3*TAG_W +: TAG_W] = TAG_W'('h2A);
    exp_wen = '1;
    exp_wen[3*TAG_W +: TAG_W] = '0;
    exp_data = '0;
    exp_data[3*TAG_W +: TAG_W] = TAG_W'('h2A);
    a_req_vld = 1; a_req_wr = 1; a_req_idx = 5; a_req_way_wen = 16'h0008; a_req_din = wdata;
    #1;
    checks++;
    if ({a_req_rdy, tag_cen, tag_gwen} !== 3'b100 || tag_idx !== IDX_W'(5) ||
        tag_wen !== exp_wen || tag_din !== wdata) begin
      errors++;
      $display("[TB] FAIL write_way3: rdy/cen/gwen=%b idx=%0d wen=%h got, 100 idx=5 wen=%h required",
               {a_req_rdy, tag_cen, tag_gwen}, tag_idx, tag_wen, exp_wen);
    end
    next_cycle();
    a_req_wr = 0;
    #1;
    checks++;
    if ({a_req_rdy, tag_cen, tag_gwen, rsp_vld} !== 4'b1010 || tag_idx !== IDX_W'(5)) begin
      errors++;
      $display("[TB] FAIL read_grant: rdy/cen/gwen/rsp=%b idx=%0d got, 1010 idx=5 required",
               {a_req_rdy, tag_cen, tag_gwen, rsp_vld}, tag_idx);
    end
    next_cycle();
    a_req_vld = 0;
    #1;
    checks++;
    if ({rsp_vld, rsp_src, tag_cen} !== 3'b101 || rsp_dout !== exp_data) begin
      errors++;
      $display("[TB] FAIL read_rsp: vld/src/cen=%b dout=%h got, 101 dout=%h required",
               {rsp_vld, rsp_src, tag_cen}, rsp_dout, exp_data);
    end
    next_cycle();
  endtask

  task automatic test_write_zero_wen();
    a_req_vld = 1; a_req_wr = 1; a_req_idx = 7; a_req_way_wen = '0; a_req_din = '1;
    #1;
    checks++;
    if ({a_req_rdy, tag_cen} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL zero_wen: rdy/cen=%b got, 11 required", {a_req_rdy, tag_cen});
    end
    next_cycle();
    a_req_wr = 0;
    #1;
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_wen_rsp: rsp_vld=%b got, 0 required", rsp_vld);
    end
    next_cycle();
    a_req_vld = 0;
    #1;
    checks++;
    if (rsp_vld !== 1'b1 || rsp_dout !== '0) begin
      errors++;
      $display("[TB] FAIL zero_wen_data: vld=%b dout=%h got, 1 and 0 required", rsp_vld, rsp_dout);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_b, prev_b;
    int b_wait, max_wait;
    wdata = '0;
    wdata[0 +: TAG_W] = TAG_W'('h11);
    b_req_vld = 1; b_req_wr = 1; b_req_idx = 2; b_req_way_wen = 16'h0001; b_req_din = wdata;
    #1;
    checks++;
    if ({a_req_rdy, b_req_rdy, tag_cen, tag_gwen} !== 4'b1100 || tag_idx !== IDX_W'(2)) begin
      errors++;
      $display("[TB] FAIL b_alone_write: ardy/brdy/cen/gwen=%b idx=%0d got, 1100 idx=2 required",
               {a_req_rdy, b_req_rdy, tag_cen, tag_gwen}, tag_idx);
    end
    next_cycle();
    a_req_vld = 1; a_req_wr = 0; a_req_idx = 1;
    b_req_wr = 0;
    prev_b = 0; b_wait = 0; max_wait = 0;
    for (int k = 0; k < 24; k++) begin
      #1;
      exp_b = (k % 8 == 7);
      checks++;
      if (a_req_rdy !== !exp_b || b_req_rdy !== exp_b || tag_cen !== 1'b0 || tag_gwen !== 1'b1 ||
          tag_idx !== (exp_b ? IDX_W'(2) : IDX_W'(1))) begin
        errors++;
        $display("[TB] FAIL arb_grant[%0d]: ardy=%b brdy=%b idx=%0d got, ardy=%b brdy=%b required",
                 k, a_req_rdy, b_req_rdy, tag_idx, !exp_b, exp_b);
      end
      checks++;
      if (k == 0) begin
        if (rsp_vld !== 1'b0) begin
          errors++;
          $display("[TB] FAIL arb_rsp[0]: rsp_vld=%b got, 0 required", rsp_vld);
        end
      end else if (rsp_vld !== 1'b1 || rsp_src !== prev_b || rsp_dout !== (prev_b ? wdata : '0)) begin
        errors++;
        $display("[TB] FAIL arb_rsp[%0d]: vld=%b src=%b dout=%h got, 1 src=%b required",
                 k, rsp_vld, rsp_src, rsp_dout, prev_b);
      end
      if (b_req_rdy) b_wait = 0;
      else b_wait++;
      if (b_wait > max_wait) max_wait = b_wait;
      prev_b = exp_b;
      next_cycle();
    end
    a_req_vld = 0; b_req_vld = 0;
    #1;
    checks++;
    if (max_wait > STARVE_MAX || rsp_vld !== 1'b1 || rsp_src !== 1'b1 || rsp_dout !== wdata) begin
      errors++;
      $display("[TB] FAIL arb_tail: max_wait=%0d vld=%b src=%b got, wait<=%0d vld=1 src=1 required",
               max_wait, rsp_vld, rsp_src, STARVE_MAX);
    end
    next_cycle();
  endtask

  task automatic test_inv_mid_rsp();
    int done_cnt;
    done_cnt = 0;
    exp_data = '0;
    exp_data[0 +: TAG_W] = TAG_W'('h55);
    a_req_vld = 1; a_req_wr = 1; a_req_idx = 9; a_req_way_wen = 16'h0001; a_req_din = exp_data;
    next_cycle();
    a_req_wr = 0;
    #1;
    checks++;
    if ({a_req_rdy, tag_cen, tag_gwen} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL inv_pre_read: rdy/cen/gwen=%b got, 101 required", {a_req_rdy, tag_cen, tag_gwen});
    end
    next_cycle();
    inv_req = 1; a_req_idx = 4;
    #1;
    checks++;
    if ({a_req_rdy, b_req_rdy, tag_cen, rsp_vld, rsp_src, init_busy} !== 6'b001100 || rsp_dout !== exp_data) begin
      errors++;
      $display("[TB] FAIL inv_cycle: ardy/brdy/cen/rsp/src/busy=%b dout=%h got, 001100 dout=%h required",
               {a_req_rdy, b_req_rdy, tag_cen, rsp_vld, rsp_src, init_busy}, rsp_dout, exp_data);
    end
    next_cycle();
    a_req_idx = 9;
    for (int i = 0; i < 16; i++) begin
      inv_req = (i < 8);
      #1;
      checks++;
      if ({tag_cen, tag_gwen, init_busy, a_req_rdy} !== 4'b0010 || tag_wen !== '0 || tag_idx !== IDX_W'(i)) begin
        errors++;
        $display("[TB] FAIL inv_sweep[%0d]: cen/gwen/busy/ardy=%b idx=%0d got, 0010 idx=%0d required",
                 i, {tag_cen, tag_gwen, init_busy, a_req_rdy}, tag_idx, i);
      end
      if (inv_done) done_cnt++;
      next_cycle();
    end
    #1;
    checks++;
    if ({inv_done, init_busy, a_req_rdy, tag_cen, tag_gwen} !== 5'b10101 || tag_idx !== IDX_W'(9) || done_cnt != 0) begin
      errors++;
      $display("[TB] FAIL inv_done: done/busy/ardy/cen/gwen=%b idx=%0d early=%0d got, 10101 idx=9 0 required",
               {inv_done, init_busy, a_req_rdy, tag_cen, tag_gwen}, tag_idx, done_cnt);
    end
    next_cycle();
    a_req_vld = 0;
    #1;
    checks++;
    if (rsp_vld !== 1'b1 || rsp_dout !== '0 || inv_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inv_cleared: vld=%b done=%b dout=%h got, 1 0 and 0 required", rsp_vld, inv_done, rsp_dout);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt;
    done_cnt = 0;
    inv_req = 1;
    next_cycle();
    inv_req = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (inv_done) done_cnt++;
      next_cycle();
    end
    cpurst = 1;
    #1;
    checks++;
    if ({tag_cen, init_busy, inv_done} !== 3'b100 || tag_idx !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_idle: cen/busy/done=%b idx=%0d got, 100 idx=0 required",
               {tag_cen, init_busy, inv_done}, tag_idx);
    end
    next_cycle();
    cpurst = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({tag_cen, tag_gwen, init_busy} !== 3'b001 || tag_idx !== IDX_W'(i)) begin
        errors++;
        $display("[TB] FAIL rst_mid_sweep[%0d]: cen/gwen/busy=%b idx=%0d got, 001 idx=%0d required",
                 i, {tag_cen, tag_gwen, init_busy}, tag_idx, i);
      end
      if (inv_done) done_cnt++;
      next_cycle();
    end
    #1;
    checks++;
    if (inv_done !== 1'b1 || init_busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_done: done=%b busy=%b early=%0d got, 1 0 0 required", inv_done, init_busy, done_cnt);
    end
    next_cycle();
    #1;
    checks++;
    if (inv_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_single: done=%b got, 0 required", inv_done);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_zero_wen();
    test_back_to_back();
    test_inv_mid_rsp();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at 200000");
    $fatal(1, "[TB] timeout");
  end
endmodule
